vend_controller: RTL and testbench

//  Sequencing controller for a two-item coin vending machine. Accumulates coin credit,

---
 rtl/vend_controller.sv | 134 +++++++++++++
 tb/tb_vend_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - two-item coin vending sequencer: credit, select, dispense, change payout
// Outputs are registered copies of the next-state decode so every output changes only on a clock edge.
module vend_controller #(
   parameter int PRICE_A    = 15,
   parameter int PRICE_B    = 25,
   parameter int MAX_CREDIT = 95,
   parameter int TIMEOUT    = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       sel_valid,
   input  logic       sel_item,
   input  logic       cancel,
   output logic       vend_req,
   output logic       vend_item,
   input  logic       vend_ack,
   output logic       pay_valid,
   output logic       pay_coin,
   input  logic       pay_ready,
   output logic [6:0] credit,
   output logic       coin_reject,
   output logic       sel_denied,
   output logic       busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [6:0]    credit_n;
   logic          vend_item_n, pay_coin_n, coin_reject_n, sel_denied_n;
   logic [7:0]    coin_value, price, credit_sum;
   logic          coin_ok, sel_ok;

   always_comb begin
      case (coin_type)
         2'b00:   coin_value = 8'd5;
         2'b01:   coin_value = 8'd10;
         2'b10:   coin_value = 8'd25;
         default: coin_value = 8'd0;
      endcase
      price      = sel_item ? 8'(PRICE_B) : 8'(PRICE_A);
      credit_sum = {1'b0, credit} + coin_value;
      // An unaffordable price (including one above the ceiling) simply never satisfies sel_ok.
      coin_ok    = coin_valid && (coin_type != 2'b11) && (int'(credit_sum) <= MAX_CREDIT);
      sel_ok     = int'({1'b0, credit}) >= (sel_item ? PRICE_B : PRICE_A);
   end

   always_comb begin
      state_n       = state;
      timer_n       = timer;
      credit_n      = credit;
      vend_item_n   = vend_item;
      coin_reject_n = coin_valid;
      sel_denied_n  = sel_valid;
      case (state)
         IDLE: begin
            if (coin_ok) begin
               credit_n      = coin_value[6:0];
               state_n       = CREDIT;
               timer_n       = '0;
               coin_reject_n = 1'b0;
            end
         end
         CREDIT: begin
            if (cancel) begin
               state_n = CHANGE;
            end else begin
               coin_reject_n = coin_valid && !coin_ok;
               sel_denied_n  = sel_valid && !sel_ok;
               // Selection is judged on pre-coin credit; a same-cycle coin still lands.
               credit_n = credit + (coin_ok ? coin_value[6:0] : 7'd0)
                                 - ((sel_valid && sel_ok) ? price[6:0] : 7'd0);
               if (sel_valid && sel_ok) begin
                  state_n     = VEND;
                  vend_item_n = sel_item;
               end else if (coin_ok || sel_valid) begin
                  timer_n = '0;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  state_n = CHANGE;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
         end
         VEND: begin
            if (vend_ack) begin
               state_n = (credit != 7'd0) ? CHANGE : IDLE;
            end
         end
         CHANGE: begin
            if (pay_valid && pay_ready) begin
               credit_n = credit - (pay_coin ? 7'd10 : 7'd5);
               if (credit_n == 7'd0) begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      pay_coin_n = (state_n == CHANGE) && (credit_n >= 7'd10);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         credit      <= 7'd0;
         vend_req    <= 1'b0;
         vend_item   <= 1'b0;
         pay_valid   <= 1'b0;
         pay_coin    <= 1'b0;
         coin_reject <= 1'b0;
         sel_denied  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         credit      <= credit_n;
         vend_req    <= (state_n == VEND);
         vend_item   <= vend_item_n;
         pay_valid   <= (state_n == CHANGE);
         pay_coin    <= pay_coin_n;
         coin_reject <= coin_reject_n;
         sel_denied  <= sel_denied_n;
         busy        <= (state_n == VEND) || (state_n == CHANGE);
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed and randomized checks of vend_controller against a transaction model
module tb_vend_controller;

   localparam int PA = 15;
   localparam int PB = 25;
   localparam int MC = 95;
   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_type = 2'b00;
   logic       sel_valid = 1'b0;
   logic       sel_item = 1'b0;
   logic       cancel = 1'b0;
   logic       vend_ack = 1'b0;
   logic       pay_ready = 1'b0;
   logic       vend_req, vend_item, pay_valid, pay_coin, coin_reject, sel_denied, busy;
   logic [6:0] credit;

   int tests = 0;
   int fails = 0;
   int m_phase, m_credit, m_idle, m_item, m_rej, m_den;
   int n_vend, n_dime, n_nickel;

   vend_controller #(.PRICE_A(PA), .PRICE_B(PB), .MAX_CREDIT(MC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
      .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
      .vend_req(vend_req), .vend_item(vend_item), .vend_ack(vend_ack),
      .pay_valid(pay_valid), .pay_coin(pay_coin), .pay_ready(pay_ready),
      .credit(credit), .coin_reject(coin_reject), .sel_denied(sel_denied), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int value(input logic [1:0] t);
      case (t)
         2'b00:   return 5;
         2'b01:   return 10;
         2'b10:   return 25;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0; m_credit = 0; m_idle = 0; m_item = 0; m_rej = 0; m_den = 0;
   endtask

   // phase: 0 idle, 1 holding credit, 2 dispensing, 3 paying change
   task automatic model_edge();
      int v, pr;
      bit ok, vend;
      v = value(coin_type);
      pr = sel_item ? PB : PA;
      m_rej = 0; m_den = 0;
      case (m_phase)
         0: begin
            if (coin_valid) begin
               if (coin_type != 2'b11 && v <= MC) begin
                  m_credit = v; m_phase = 1; m_idle = 0;
               end else m_rej = 1;
            end
            m_den = int'(sel_valid);
         end
         1: begin
            if (cancel) begin
               m_phase = 3; m_rej = int'(coin_valid); m_den = int'(sel_valid);
            end else begin
               ok   = coin_valid && coin_type != 2'b11 && (m_credit + v <= MC);
               vend = sel_valid && (m_credit >= pr);
               m_rej = int'(coin_valid && !ok);
               m_den = int'(sel_valid && !vend);
               m_credit = m_credit + (ok ? v : 0) - (vend ? pr : 0);
               if (vend) begin
                  m_phase = 2; m_item = int'(sel_item);
               end else if (ok || m_den != 0) begin
                  m_idle = 0;
               end else begin
                  m_idle++;
                  if (m_idle == TO) m_phase = 3;
               end
            end
         end
         2: begin
            m_rej = int'(coin_valid); m_den = int'(sel_valid);
            if (vend_ack) m_phase = (m_credit > 0) ? 3 : 0;
         end
         default: begin
            m_rej = int'(coin_valid); m_den = int'(sel_valid);
            if (pay_ready) begin
               m_credit -= (m_credit >= 10) ? 10 : 5;
               if (m_credit == 0) m_phase = 0;
            end
         end
      endcase
   endtask

   task automatic check_all();
      chk("credit", 32'(credit), 32'(m_credit));
      chk("vend_req", 32'(vend_req), 32'(m_phase == 2));
      chk("vend_item", 32'(vend_item), 32'(m_item));
      chk("pay_valid", 32'(pay_valid), 32'(m_phase == 3));
      chk("pay_coin", 32'(pay_coin), 32'(m_phase == 3 && m_credit >= 10));
      chk("coin_reject", 32'(coin_reject), 32'(m_rej));
      chk("sel_denied", 32'(sel_denied), 32'(m_den));
      chk("busy", 32'(busy), 32'(m_phase >= 2));
   endtask

   task automatic step();
      if (pay_valid && pay_ready) begin
         if (pay_coin) n_dime++; else n_nickel++;
      end
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (vend_req) n_vend++;
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; vend_ack = 1'b0;
   endtask

   task automatic clr_counts();
      n_vend = 0; n_dime = 0; n_nickel = 0;
   endtask

   task automatic do_coin(input logic [1:0] t);
      coin_valid = 1'b1; coin_type = t; step();
   endtask

   task automatic do_sel(input logic i);
      sel_valid = 1'b1; sel_item = i; step();
   endtask

   task automatic ack_and_drain();
      vend_ack = 1'b1; step();
      pay_ready = 1'b1;
      for (int k = 0; k < 30 && pay_valid; k++) step();
      pay_ready = 1'b0;
      chk("drain_done", 32'(pay_valid), 32'd0);
   endtask

   initial begin
      model_reset();
      clr_counts();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // 1: 25c, select A, ack in third vend cycle, one dime back
      clr_counts();
      do_coin(2'b10);
      do_sel(1'b0);
      step(); step();
      ack_and_drain();
      chk("t1_vend_cycles", 32'(n_vend), 32'd3);
      chk("t1_dimes", 32'(n_dime), 32'd1);
      chk("t1_nickels", 32'(n_nickel), 32'd0);

      // 2: 15c denied for B, then 25c exact vend with no change
      clr_counts();
      do_coin(2'b00); do_coin(2'b01);
      do_sel(1'b1);
      chk("t2_denied", 32'(sel_denied), 32'd1);
      chk("t2_credit", 32'(credit), 32'd15);
      do_coin(2'b01);
      do_sel(1'b1);
      ack_and_drain();
      chk("t2_payouts", 32'(n_dime + n_nickel), 32'd0);

      // 3: fourth quarter rejected, cancel refund with hopper stalls
      clr_counts();
      repeat (4) do_coin(2'b10);
      chk("t3_credit", 32'(credit), 32'd75);
      cancel = 1'b1; step();
      for (int k = 0; k < 20 && pay_valid; k++) begin
         pay_ready = 1'b0; step(); step();
         pay_ready = 1'b1; step();
      end
      pay_ready = 1'b0;
      chk("t3_dimes", 32'(n_dime), 32'd7);
      chk("t3_nickels", 32'(n_nickel), 32'd1);
      chk("t3_credit_end", 32'(credit), 32'd0);

      // 4: same-cycle coin and select use pre-coin credit
      clr_counts();
      do_coin(2'b01);
      coin_valid = 1'b1; coin_type = 2'b10; sel_valid = 1'b1; sel_item = 1'b0; step();
      chk("t4_denied", 32'(sel_denied), 32'd1);
      chk("t4_credit", 32'(credit), 32'd35);
      do_sel(1'b0);
      ack_and_drain();
      chk("t4_change", 32'(n_dime * 10 + n_nickel * 5), 32'd20);

      // 5: invalid coin and coin during vend both rejected
      do_coin(2'b11);
      chk("t5_reject_invalid", 32'(coin_reject), 32'd1);
      do_coin(2'b10); do_sel(1'b0);
      do_coin(2'b00);
      chk("t5_reject_vend", 32'(coin_reject), 32'd1);
      chk("t5_credit", 32'(credit), 32'd10);
      ack_and_drain();

      // 6: timeout refund, then asynchronous reset mid-vend
      clr_counts();
      do_coin(2'b00);
      repeat (TO) step();
      chk("t6_timeout", 32'(pay_valid), 32'd1);
      pay_ready = 1'b1; step(); pay_ready = 1'b0;
      chk("t6_nickel", 32'(n_nickel), 32'd1);
      do_coin(2'b10); do_sel(1'b0); step();
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_outputs", 32'({vend_req, vend_item, pay_valid, pay_coin, coin_reject, sel_denied, busy}), 32'd0);
      chk("t6_rst_credit", 32'(credit), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         coin_valid = ($urandom_range(0, 9) < 3);
         coin_type  = 2'($urandom_range(0, 3));
         sel_valid  = ($urandom_range(0, 9) < 2);
         sel_item   = 1'($urandom_range(0, 1));
         cancel     = ($urandom_range(0, 39) == 0);
         vend_ack   = ($urandom_range(0, 9) < 3);
         pay_ready  = ($urandom_range(0, 1) == 1);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
